// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - pipeline-side and data-bus-side signals of the load/store sequencer
// master = pipeline/memory environment, slave = lsu_ctrl
interface lsu_ctrl_if;
  logic        op_valid;
  logic        op_load;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;
  logic [31:0] badvaddr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output op_valid, op_load, op_store, op_size, op_unsigned, addr, wdata,
    output mem_ack, mem_rdata,
    input  stall, rdata_out, rdata_valid, exc_adel, exc_ades, bus_err, badvaddr,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  op_valid, op_load, op_store, op_size, op_unsigned, addr, wdata,
    input  mem_ack, mem_rdata,
    output stall, rdata_out, rdata_valid, exc_adel, exc_ades, bus_err, badvaddr,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: alignment check, lane steering, stall and bus timeout
// One access in flight at a time: IDLE accepts, WAIT holds the bus request, DONE reports for one cycle.
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] badv_q, badv_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic        access, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  // Reset also masks the request so combinational outputs fall with it.
  assign access     = bus.op_valid & (bus.op_load | bus.op_store) & ~rst;
  assign misaligned = (bus.op_size == 2'b01 && bus.addr[0]) ||
                      (bus.op_size[1] && bus.addr[1:0] != 2'b00);

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = bus.wdata;
    case (bus.op_size)
      2'b00: begin
        be_calc    = 4'b0001 << bus.addr[1:0];
        wdata_calc = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_ext = bus.mem_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    badv_d       = badv_q;
    be_d         = be_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_d       = load_q;
    err_d        = err_q;
    bus.stall    = 1'b0;
    bus.exc_adel = 1'b0;
    bus.exc_ades = 1'b0;
    bus.badvaddr = badv_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            bus.exc_adel = bus.op_load;
            bus.exc_ades = ~bus.op_load;
            bus.badvaddr = bus.addr;
          end else begin
            bus.stall = 1'b1;
            addr_d    = bus.addr;
            wdata_d   = wdata_calc;
            be_d      = be_calc;
            size_d    = bus.op_size;
            uns_d     = bus.op_unsigned;
            load_d    = bus.op_load;
            err_d     = 1'b0;
            cnt_d     = '0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        bus.stall = 1'b1;
        if (bus.mem_ack) begin
          if (load_q) rdata_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == 10'(TIMEOUT - 1)) begin
          rdata_d = '0;
          badv_d  = addr_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      badv_q  <= '0;
      be_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      badv_q  <= badv_d;
      be_q    <= be_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_req     = (state_q == WAIT);
  assign bus.mem_we      = ~load_q & (state_q != IDLE);
  assign bus.mem_addr    = {addr_q[31:2], 2'b00};
  assign bus.mem_be      = be_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.rdata_out   = rdata_q;
  assign bus.rdata_valid = (state_q == DONE) & load_q;
  assign bus.bus_err     = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with directed load/store vectors
module tb_lsu_ctrl;

  localparam int K_RD = 1, K_ADEL = 2, K_ADES = 3, K_ERR = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  logic req_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bus request or a response.
  initial begin
    req_t r;
    rsp_t s;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.mem_req && !req_prev) begin
          if (exp_req_q.size() == 0) unexpected("mem_req");
          else begin
            r = exp_req_q.pop_front();
            chk("mem_addr", bus.mem_addr, r.addr);
            chk("mem_be", {28'd0, bus.mem_be}, {28'd0, r.be});
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, r.we});
            chk("mem_wdata", bus.mem_wdata, r.wdata);
          end
        end
        if (bus.bus_err || bus.rdata_valid || bus.exc_adel || bus.exc_ades) begin
          if (exp_rsp_q.size() == 0) unexpected("response");
          else begin
            s = exp_rsp_q.pop_front();
            if (bus.bus_err) begin
              chk("kind_err", K_ERR, s.kind);
              chk("err_badvaddr", bus.badvaddr, s.data);
              chk("err_rdata", bus.rdata_out, 32'd0);
            end else if (bus.rdata_valid) begin
              chk("kind_rd", K_RD, s.kind);
              chk("rdata_out", bus.rdata_out, s.data);
            end else if (bus.exc_adel) begin
              chk("kind_adel", K_ADEL, s.kind);
              chk("adel_badvaddr", bus.badvaddr, s.data);
            end else begin
              chk("kind_ades", K_ADES, s.kind);
              chk("ades_badvaddr", bus.badvaddr, s.data);
            end
          end
        end
      end
      req_prev = bus.mem_req;
    end
  end

  task automatic drive_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.op_valid    = 1'b1;
    bus.op_load     = ld;
    bus.op_store    = st;
    bus.op_size     = sz;
    bus.op_unsigned = uns;
    bus.addr        = a;
    bus.wdata       = wd;
  endtask

  // ack_at: WAIT cycle (1-based) in which mem_ack is driven; 0 = never.
  task automatic do_op(input string name, input bit ld, input bit st, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at,
                       input int exp_stall, input int exp_reqc,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input int kind, input logic [31:0] edata);
    int stall_cnt = 0;
    int req_cnt   = 0;
    bit ended     = 1'b0;
    if (exp_reqc > 0) exp_req_q.push_back('{{a[31:2], 2'b00}, ebe, ~ld, ewd});
    if (kind != 0) exp_rsp_q.push_back('{kind, edata});
    @(negedge clk);
    drive_op(ld, st, sz, uns, a, wd);
    #1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.stall) stall_cnt++;
      if (bus.mem_req) begin
        req_cnt++;
        bus.mem_ack   = (req_cnt == ack_at);
        bus.mem_rdata = rd;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (!bus.stall) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ended) unexpected({name, "_hang"});
    chk({name, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({name, "_req_cycles"}, req_cnt, exp_reqc);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_load = 1'b0; bus.op_store = 1'b0; bus.op_size = 2'b00;
    bus.op_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_rdata_out", bus.rdata_out, 32'd0);
    chk("rst_badvaddr", bus.badvaddr, 32'd0);
    chk("rst_flags", {27'd0, bus.rdata_valid, bus.bus_err, bus.exc_adel, bus.exc_ades, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("lb",  1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, 2, 1, 4'b1000, 32'h0, K_RD, 32'hFFFF_FF80);
    do_op("lhu", 1, 0, 2'b01, 1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 3, 4, 3, 4'b1100, 32'h0, K_RD, 32'h0000_8001);
    do_op("sb",  0, 1, 2'b00, 0, 32'h0000_0001, 32'h1234_56AB, 32'h0, 1, 2, 1, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
    do_op("sh",  0, 1, 2'b01, 0, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 2, 3, 2, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
    do_op("lw_mis", 1, 0, 2'b10, 0, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, K_ADEL, 32'h0000_1002);
    do_op("sh_mis", 0, 1, 2'b01, 0, 32'h0000_0007, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, K_ADES, 32'h0000_0007);
    do_op("lh",  1, 0, 2'b01, 0, 32'h0000_0000, 32'h0, 32'h1234_8765, 1, 2, 1, 4'b0011, 32'h0, K_RD, 32'hFFFF_8765);
    do_op("lbu", 1, 0, 2'b00, 1, 32'h0000_0002, 32'h0, 32'h00AB_0000, 1, 2, 1, 4'b0100, 32'h0, K_RD, 32'h0000_00AB);
    do_op("lw_ld_st", 1, 1, 2'b11, 1, 32'h0000_0008, 32'h5555_5555, 32'hDEAD_BEEF, 2, 3, 2, 4'b1111, 32'h5555_5555, K_RD, 32'hDEAD_BEEF);
    do_op("sw",  0, 1, 2'b10, 0, 32'h0000_0004, 32'hA5A5_0F0F, 32'h0, 1, 2, 1, 4'b1111, 32'hA5A5_0F0F, 0, 32'h0);
    do_op("lw_tmo", 1, 0, 2'b10, 0, 32'h0000_0300, 32'h0, 32'h1111_1111, 0, 5, 4, 4'b1111, 32'h0, K_ERR, 32'h0000_0300);

    exp_req_q.push_back('{32'h0000_0500, 4'b1111, 1'b0, 32'h0});
    @(negedge clk);
    drive_op(1, 0, 2'b10, 0, 32'h0000_0500, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("arst_stall", {31'd0, bus.stall}, 32'd0);
    chk("arst_rdata_out", bus.rdata_out, 32'd0);
    bus.op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op("lw_after_rst", 1, 0, 2'b10, 0, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1, 2, 1, 4'b1111, 32'h0, K_RD, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    chk("req_queue_empty", exp_req_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the pipeline MEM stage and the data-memory bus.
- Accepts one access at a time, checks alignment, drives byte enables and replicated store data, and holds the pipeline with a stall until the bus acknowledges.
- For loads, selects the addressed byte or halfword lane and sign- or zero-extends it to 32 bits, as LB/LBU/LH/LHU/LW require.
- A bus timeout converts a hung access into a bus-error pulse.

Parameters:
- TIMEOUT, 255, wait cycles allowed without mem_ack before a bus error is flagged (1..1023).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  MEM stage presents an access this cycle.
- op_load  input  1  access is a load. Takes priority if op_store is also high.
- op_store  input  1  access is a store.
- op_size  input  2  00 = byte, 01 = half, 10 or 11 = word.
- op_unsigned  input  1  1 = zero-extend the load result, 0 = sign-extend it.
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified.
- stall  output  1  pipeline hold request.
- rdata_out  output  32  extended load result.
- rdata_valid  output  1  one-cycle pulse; rdata_out is valid while it is high.
- exc_adel  output  1  misaligned load.
- exc_ades  output  1  misaligned store.
- bus_err  output  1  one-cycle timeout pulse.
- badvaddr  output  32  faulting address.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  32  word-aligned address, i.e. {addr[31:2], 2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  bus completion.
- mem_rdata  input  32  bus read data, valid when mem_ack is high.

Behaviour:
- States:
  - IDLE.
  - WAIT.
  - DONE.
- Reset: state = IDLE; all outputs and registers go to 0 immediately. An access in flight is abandoned and mem_req drops asynchronously.
- Access and misalignment:
  - An access is op_valid & (op_load | op_store).
  - It is misaligned when op_size = 01 and addr[0] = 1, or when op_size is a word and addr[1:0] != 0.
- IDLE, aligned access:
  - stall = 1 combinationally in the same cycle.
  - addr, size, unsigned, we and wdata are latched.
  - Next state is WAIT; the wait counter is cleared.
- IDLE, misaligned access:
  - No bus activity, stall = 0.
  - exc_adel (load) or exc_ades (store) = 1 combinationally for that cycle.
  - badvaddr = addr combinationally.
  - State stays IDLE.
- WAIT:
  - mem_req = 1 (registered, first high in the cycle after acceptance); stall = 1.
  - mem_addr, mem_be, mem_we and mem_wdata are driven from the latched values and held stable until ack.
  - On mem_ack sampled high: mem_req = 0 on the next edge, go to DONE.
  - For a load, rdata_out is registered on that same edge.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT without an ack: mem_req drops, rdata_out = 0, badvaddr = latched address, go to DONE with bus_err flagged.
- DONE:
  - Exactly one cycle; stall = 0.
  - rdata_valid = 1 for loads only; bus_err = 1 only if the access timed out.
  - op_valid in DONE is ignored, because the held instruction is still presented; the next op is evaluated in the following IDLE cycle.
  - Next state is IDLE.
- Minimum aligned-access latency: the accept cycle, at least 1 WAIT cycle, then 1 DONE cycle. With a zero-wait bus (ack in the first WAIT cycle) stall is high for 2 cycles.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction:
  - byte: b = mem_rdata[8*addr[1:0] +: 8]; rdata_out = {24{~op_unsigned & b[7]}, b}.
  - half: h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0]; rdata_out = {16{~op_unsigned & h[15]}, h}.
  - word: mem_rdata unchanged; op_unsigned is ignored.
- mem_ack while not in WAIT is ignored.
- rdata_out holds its value until the next load completes.
- Stores never assert rdata_valid.

Test Plan:
- LB, addr = 0x103, op_unsigned = 0, mem_rdata = 0x80FF_1234, ack in the first WAIT cycle: mem_be = 0001 << 3 = 1000, mem_addr = 0x100, rdata_out = 0xFFFF_FF80, rdata_valid is a single pulse, stall high for exactly 2 cycles.
- LHU, addr = 0x202, mem_rdata = 0x8001_7FFF, ack after 3 WAIT cycles: mem_be = 1100, rdata_out = 0x0000_8001, stall high for 4 cycles, mem_req high for 3 cycles.
- SB, addr = 0x1, wdata = 0x1234_56AB: mem_we = 1, mem_be = 0010, mem_wdata = 0xABAB_ABAB, no rdata_valid. SH to 0x2 with wdata 0x0000_BEEF gives mem_be = 1100 and mem_wdata = 0xBEEF_BEEF.
- LW to 0x1002: exc_adel = 1 and badvaddr = 0x1002 in the same cycle, no mem_req, stall = 0. SH to 0x7 gives exc_ades = 1.
- TIMEOUT = 4, load with no ack: mem_req high for 4 cycles then low, bus_err is a single pulse, rdata_out = 0, badvaddr = the latched address.
- rst asserted mid-WAIT: mem_req and stall drop asynchronously, state = IDLE; a subsequent LW to 0x0 completes normally.
